// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared types, constants and phase-length helpers for the clock divider
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  // High phase takes the extra cycle of an odd divisor.
  function automatic logic [31:0] lo_len(input logic [31:0] n);
    return n >> 1;
  endfunction

  function automatic logic [31:0] hi_len(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_cfg_slot.sv
// rtl/clk_div_cfg_slot.sv - single-entry pending-divisor register with range check
module clk_div_cfg_slot
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             take,
  output logic             pend_valid,
  output logic [CNT_W-1:0] pend_div
);

  logic accept;

  assign cfg_ready = ~pend_valid;
  assign accept    = cfg_valid & cfg_ready;

  // take only fires with a full slot and accept only with an empty one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_div   <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (take) begin
        pend_valid <= 1'b0;
      end
      if (accept) begin
        if (32'(cfg_div) >= MIN_DIV) begin
          pend_valid <= 1'b1;
          pend_div   <= cfg_div;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with boundary-aligned divisor updates
module clk_div_ctrl
  import clk_gen_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_div
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_d;
  logic [CNT_W-1:0] start_div;
  logic             pend_valid;
  logic [CNT_W-1:0] pend_div;
  logic             take;
  logic             start;
  logic             tick_d, clk_out_d, running_d;

  clk_div_cfg_slot #(.CNT_W(CNT_W)) u_slot (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .take       (take),
    .pend_valid (pend_valid),
    .pend_div   (pend_div)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_div <= CNT_W'(DIV_RST);
      clk_out <= 1'b0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_div <= div_d;
      clk_out <= clk_out_d;
      tick    <= tick_d;
      running <= running_d;
    end
  end

  // A new period starts from IDLE, or at the end of LOW, only while en is held.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = cur_div;
    take      = 1'b0;
    start_div = pend_valid ? pend_div : cur_div;
    start     = en & ((state_q == IDLE) | ((state_q == LOW) & (cnt_q == '0)));
    if (start) begin
      state_d = HIGH;
      div_d   = start_div;
      take    = pend_valid;
      cnt_d   = CNT_W'(hi_len(32'(start_div)) - 32'd1);
    end else begin
      unique case (state_q)
        IDLE: ;
        HIGH: begin
          if (cnt_q == '0) begin
            state_d = LOW;
            cnt_d   = CNT_W'(lo_len(32'(cur_div)) - 32'd1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tick_d    = start;
    clk_out_d = (state_d == HIGH);
    running_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic        clk_out;
  logic        tick;
  logic        running;
  logic [15:0] cur_div;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(.CNT_W(16), .DIV_RST(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cur_div   (cur_div)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starting from the last cycle before a rising edge, checks h high and l low cycles.
  task automatic expect_period(input string tag, input int h, input int l);
    for (int i = 0; i < h + l; i++) begin
      step();
      chk({tag, ".clk_out"}, 32'(clk_out), (i < h) ? 32'd1 : 32'd0);
      chk({tag, ".tick"}, 32'(tick), (i == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst.clk_out", 32'(clk_out), 32'd0);
    chk("rst.tick", 32'(tick), 32'd0);
    chk("rst.running", 32'(running), 32'd0);
    chk("rst.cfg_err", 32'(cfg_err), 32'd0);
    chk("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst.cur_div", 32'(cur_div), 32'd2);

    // Out-of-range offers: N=1 then N=0 back to back.
    cfg_valid = 1'b1; cfg_div = 16'd1;
    step();
    chk("err1.cfg_err", 32'(cfg_err), 32'd1);
    chk("err1.cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_div = 16'd0;
    step();
    chk("err0.cfg_err", 32'(cfg_err), 32'd1);
    chk("err0.cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    step();
    chk("err.pulse_end", 32'(cfg_err), 32'd0);
    chk("err.cur_div", 32'(cur_div), 32'd2);
    chk("err.idle", 32'(clk_out), 32'd0);

    // Default N=2 run.
    en = 1'b1;
    expect_period("n2a", 1, 1);
    step();
    chk("n2b.clk_out", 32'(clk_out), 32'd1);
    chk("n2b.tick", 32'(tick), 32'd1);
    chk("n2b.running", 32'(running), 32'd1);
    chk("n2b.cur_div", 32'(cur_div), 32'd2);

    // Offer N=5 during HIGH; applied at the next rising edge.
    cfg_valid = 1'b1; cfg_div = 16'd5;
    step();
    cfg_valid = 1'b0;
    chk("n5.accept_ready", 32'(cfg_ready), 32'd0);
    chk("n5.old_div", 32'(cur_div), 32'd2);
    chk("n5.low", 32'(clk_out), 32'd0);
    expect_period("n5a", 3, 2);
    chk("n5.cur_div", 32'(cur_div), 32'd5);
    chk("n5.ready_back", 32'(cfg_ready), 32'd1);

    // Offer N=7 and drop en during its first HIGH phase.
    step();
    chk("n5b.rise", 32'(tick), 32'd1);
    cfg_valid = 1'b1; cfg_div = 16'd7;
    step();
    cfg_valid = 1'b0;
    chk("n7.accept_ready", 32'(cfg_ready), 32'd0);
    step(); step(); step();
    chk("n7.pre_edge", 32'(cur_div), 32'd5);
    step();
    chk("n7.tick", 32'(tick), 32'd1);
    chk("n7.cur_div", 32'(cur_div), 32'd7);
    en = 1'b0;
    for (int i = 1; i < 7; i++) begin
      step();
      chk("n7stop.clk_out", 32'(clk_out), (i < 4) ? 32'd1 : 32'd0);
      chk("n7stop.tick", 32'(tick), 32'd0);
      chk("n7stop.running", 32'(running), 32'd1);
    end
    step();
    chk("stop.running", 32'(running), 32'd0);
    chk("stop.tick", 32'(tick), 32'd0);
    step();
    chk("stop.hold", 32'(clk_out), 32'd0);
    chk("stop.notick", 32'(tick), 32'd0);

    // Offer N=4 on the LOW->HIGH boundary cycle: old N=7 keeps one more period.
    en = 1'b1;
    expect_period("n7run", 4, 3);
    cfg_valid = 1'b1; cfg_div = 16'd4;
    step();
    cfg_valid = 1'b0;
    chk("bnd.tick", 32'(tick), 32'd1);
    chk("bnd.old_div", 32'(cur_div), 32'd7);
    chk("bnd.ready", 32'(cfg_ready), 32'd0);
    for (int i = 1; i < 7; i++) begin
      step();
      chk("bnd.clk_out", 32'(clk_out), (i < 4) ? 32'd1 : 32'd0);
    end
    expect_period("n4", 2, 2);
    chk("n4.cur_div", 32'(cur_div), 32'd4);

    // Reset mid-HIGH with N=9 pending.
    step();
    chk("n4b.tick", 32'(tick), 32'd1);
    cfg_valid = 1'b1; cfg_div = 16'd9;
    step();
    cfg_valid = 1'b0;
    chk("n9.pending", 32'(cfg_ready), 32'd0);
    chk("n9.midhigh", 32'(clk_out), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2.clk_out", 32'(clk_out), 32'd0);
    chk("rst2.cur_div", 32'(cur_div), 32'd2);
    chk("rst2.cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst2.running", 32'(running), 32'd0);
    expect_period("restart", 1, 1);
    chk("restart.cur_div", 32'(cur_div), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable, run-time reconfigurable clock-divider controller for the safety FPGA's low-rate timing domain. It produces a divided clock output (`clk_out`) and an aligned one-cycle `tick` strobe, both registered in the `clk` domain. It generalises the fixed divide-by-2 generator: the divisor is programmable, start and stop are controlled, and divisor changes take effect only at period boundaries, so downstream logic never sees a runt or stretched phase.

## Interface
- `CNT_W`, 16, width of the divisor and the phase counter.
- `DIV_RST`, 2, divisor loaded at reset; must be >= 2.

Ports:
- `clk` in 1: system clock; sole clock domain.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run request; level-sensitive.
- `cfg_valid` in 1: new divisor offered.
- `cfg_div` in `CNT_W`: offered divisor N.
- `cfg_ready` out 1: pending slot is empty, so an offer can be accepted.
- `cfg_err` out 1: one-cycle pulse when an offer is rejected because N < 2.
- `clk_out` out 1: divided clock.
- `tick` out 1: one-cycle pulse coincident with each `clk_out` rising edge.
- `running` out 1: high while in HIGH or LOW.
- `cur_div` out `CNT_W`: divisor currently in use.

## Operation
- **Reset values:**
  - `clk_out`=0, `tick`=0, `running`=0, `cfg_err`=0, `cfg_ready`=1.
  - `cur_div`=`DIV_RST`; state IDLE; pending slot empty; counter 0.
- **Phase lengths for divisor N:**
  - L = N>>1, H = N − L; period = N cycles.
  - N=2 gives 1/1, N=3 gives 2/1 (high phase takes the extra cycle).
- **FSM states:** IDLE, HIGH, LOW.
  - IDLE: `clk_out`=0. If `en`=1: apply any pending divisor, go to HIGH, load counter H−1, assert `tick`.
  - HIGH: `clk_out`=1. When counter==0: go to LOW, load counter L−1. Otherwise decrement.
  - LOW: `clk_out`=0. When counter==0 and `en`=1: apply pending, go to HIGH, load counter H−1 computed from the applied divisor, assert `tick`. When counter==0 and `en`=0: go to IDLE. Otherwise decrement.
- **Deasserting `en` mid-period:** the current period always completes. No truncated phase is allowed.
- **Config handshake:** an offer is accepted on the cycle where `cfg_valid` & `cfg_ready` are both high.
  - N >= 2: N is stored in the pending slot; `cfg_ready`=0 from the next cycle.
  - N < 2: the offer is discarded; `cfg_err`=1 for one cycle next; `cfg_ready` stays 1.
- **Applying a pending divisor:** only at an IDLE→HIGH or LOW→HIGH transition.
  - `cur_div` updates in the same cycle `clk_out` rises.
  - The slot empties; `cfg_ready`=1 from the following cycle.
  - In IDLE with `en`=0, the pending divisor holds until the next start.
- **Simultaneous events:**
  - An offer accepted in the same cycle as a boundary is not applied at that boundary. It waits for the next one.
  - `rst` overrides everything.
- **Reset mid-operation:** `clk_out` is 0 the next cycle; pending divisor discarded; `cur_div`=`DIV_RST`.
- **Arithmetic:** unsigned, `CNT_W` bits. Maximum N = 2^`CNT_W`−1; H and L always fit in `CNT_W` bits.

## Timing
- `en` sampled high in IDLE at cycle t: `clk_out`=1 and `tick`=1 at t+1.
- Steady state: `tick` is exactly every N cycles; `clk_out` is high for H cycles and low for L cycles.
- After the last LOW cycle with `en`=0: `running`=0 and state IDLE on the next cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- **Package `clk_gen_pkg`:**
  - State enum (IDLE/HIGH/LOW).
  - Constant `MIN_DIV`=2.
  - Helper functions `hi_len(N)` and `lo_len(N)`.
- **Sub-module `clk_div_cfg_slot`:** single-entry holding register with valid/ready handshake and a range check. It takes `take` from the FSM and returns `pend_valid`/`pend_div`.
- **FSM and counter:** inline in `clk_div_ctrl`.

## Test plan
- Reset, then `en`=1 with default N=2: `clk_out` toggles every cycle starting at t+1, `tick` every 2 cycles, `cur_div`=2.
- Offer N=5 while running at N=2: accepted; `cfg_ready` low until the next rising edge; then the pattern is 3 high, 2 low; `cur_div`=5 coincident with that edge.
- Offer N=1 and N=0: `cfg_err` pulses once for each; `cur_div` unchanged; `cfg_ready` stays 1.
- N=7 running, drop `en` during HIGH: current 4-high/3-low period completes, then IDLE, `running`=0, no extra `tick`.
- Assert `rst` mid-HIGH with a pending N=9: `clk_out`=0 next cycle, `cur_div`=`DIV_RST`, `cfg_ready`=1; restart runs at N=2.
- Offer N=4 on the exact LOW→HIGH boundary cycle: the boundary keeps the old N, and N=4 applies at the following rising edge.
